// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, plus MTHI/MTLO writes
// and the pipeline stall. Define MULDIV_DIV_EN to build the divider datapath.
// Revision: 1.0
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mf_req,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_aabs;
    logic                 r_psgn;

    logic                 w_signed;
    logic [WIDTH-1:0]     w_aabs;
    logic [WIDTH-1:0]     w_babs;
    logic [WIDTH:0]       w_madd;
    logic [2*WIDTH-1:0]   w_mnext;
    logic [2*WIDTH-1:0]   w_prod;

    assign w_signed = ~op[0];
    assign w_aabs   = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_babs   = (w_signed && b[WIDTH-1]) ? -b : b;

    // Shift-add: upper half accumulates |a|, lower half shifts out multiplier bits.
    assign w_madd   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_aabs};
    assign w_mnext  = r_acc[0] ? {w_madd, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};
    assign w_prod   = r_psgn ? -r_acc : r_acc;

`ifdef MULDIV_DIV_EN
    logic                 r_is_div;
    logic                 r_rsgn;
    logic [WIDTH-1:0]     r_babs;

    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_sub;
    logic [2*WIDTH-1:0]   w_dnext;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_dvd;

    // Restoring step: upper half is the remainder, lower half shifts dividend
    // bits out and quotient bits in. The true difference always fits WIDTH bits.
    assign w_shift  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_babs});
    assign w_sub    = w_shift[WIDTH-1:0] - r_babs;
    assign w_dnext  = w_ge ? {w_sub, r_acc[WIDTH-2:0], 1'b1}
                           : {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    assign w_quo    = r_psgn ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem    = r_rsgn ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_dvd    = r_rsgn ? -r_aabs : r_aabs;
`else
    logic                 r_nop_pend;
`endif

    assign busy  = (r_state != S_IDLE);
    assign stall = busy & (start | mf_req | hi_we | lo_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_aabs   <= '0;
            r_psgn   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_is_div <= 1'b0;
            r_rsgn   <= 1'b0;
            r_babs   <= '0;
`else
            r_nop_pend <= 1'b0;
`endif
        end else begin
`ifdef MULDIV_DIV_EN
            done <= 1'b0;
`else
            // A DIV/DIVU without a divider completes one cycle after issue.
            done       <= r_nop_pend;
            r_nop_pend <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_aabs <= w_aabs;
                        r_psgn <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_cnt  <= '0;
`ifdef MULDIV_DIV_EN
                        r_is_div <= op[1];
                        r_babs   <= w_babs;
                        r_rsgn   <= w_signed & a[WIDTH-1];
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_aabs : w_babs)};
                        r_state  <= S_CALC;
`else
                        r_acc    <= {{WIDTH{1'b0}}, w_babs};
                        if (op[1]) begin
                            r_nop_pend <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                        end
`endif
                    end else begin
                        if (hi_we) begin
                            hi <= wdata;
                        end
                        if (lo_we) begin
                            lo <= wdata;
                        end
                    end
                end

                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
`ifdef MULDIV_DIV_EN
                    r_acc <= r_is_div ? w_dnext : w_mnext;
`else
                    r_acc <= w_mnext;
`endif
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIXUP;
                    end
                end

                S_FIXUP: begin
`ifdef MULDIV_DIV_EN
                    if (r_is_div) begin
                        if (r_babs == '0) begin
                            lo <= '1;
                            hi <= w_dvd;
                        end else begin
                            lo <= w_quo;
                            hi <= w_rem;
                        end
                    end else begin
                        {hi, lo} <= w_prod;
                    end
`else
                    {hi, lo} <= w_prod;
`endif
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the EX stage, owning the HI/LO register pair. It executes MULT/MULTU/DIV/DIVU in the background and handles MTHI/MTLO writes. It drives `stall`, which the pipeline inverts into the `en` of the IF/ID and ID/EX enable-registers so that dependent instructions are held until HI/LO are valid.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  issue a mult/div op this cycle (EX-stage decode).
- `op`  in  2  op select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  rs operand (multiplicand or dividend).
- `b`  in  WIDTH  rt operand (multiplier or divisor).
- `mf_req`  in  1  MFHI/MFLO present in EX this cycle.
- `hi_we`  in  1  MTHI write request.
- `lo_we`  in  1  MTLO write request.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO are updated by an op.
- `stall`  out  1  combinational: `busy & (start | mf_req | hi_we | lo_we)`.

## Operation
- State machine: IDLE -> CALC -> FIXUP -> IDLE.
- IDLE with `start` high:
  - Latch `op`.
  - Latch |a| and |b| (two's-complement magnitude for signed ops; raw for unsigned).
  - Latch result sign: a^b for the quotient/product; sign of a for the remainder.
  - Clear the iteration counter and go to CALC.
- CALC, multiply: radix-2 shift-add, one bit per cycle, 2·WIDTH-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, WIDTH+1-bit partial remainder.
- CALC lasts exactly WIDTH cycles, then the unit moves to FIXUP.
- FIXUP:
  - Apply the sign correction.
  - Multiply: {HI,LO} <= product.
  - Divide: LO <= quotient, HI <= remainder.
  - Pulse `done` and return to IDLE.
- `busy` = (state != IDLE).
- Requests arriving while busy: `start` is ignored and held off by `stall`; the pipeline re-presents it. `hi_we`/`lo_we` are also ignored and stalled.
- `mf_req` while busy: stalled. When idle, `hi`/`lo` outputs are read directly, with no forwarding of the same-cycle MT write.
- IDLE with `hi_we` or `lo_we`: the register is written at the next edge. `start` has priority, so a same-cycle MT write is discarded.
- Divide by zero: no trap, normal latency. Result is LO = all ones, HI = a (original signed dividend).
- Signed overflow (-2^(WIDTH-1) / -1): LO = 0x80000000, HI = 0 (WIDTH=32).
- Multiply result is full 2·WIDTH bits with no truncation. Signed product is exact, e.g. -1 × -1 = 0x00000000_00000001.

## Timing
- Reset values:
  - `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `stall` = 0.
  - State = IDLE, counter = 0.
- Reset mid-operation aborts the op. HI/LO return to 0 and no `done` is produced.
- Start accepted at edge E0.
- `busy` is high from E0 until E_(WIDTH+1), i.e. WIDTH+1 cycles.
- HI/LO are updated and `done` goes high at E_(WIDTH+1), i.e. 33 cycles for WIDTH=32.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after `done`.
- `stall` is purely combinational from registered `busy` and the inputs. It has no path through `a`, `b` or `wdata`.

## Configuration
- `MULDIV_DIV_EN` defined: DIV/DIVU are implemented as above.
- `MULDIV_DIV_EN` undefined:
  - The divider datapath is not built.
  - DIV/DIVU in IDLE leave HI/LO unchanged, never assert `busy`, and pulse `done` at E0+1.
  - MULT/MULTU behaviour is unchanged.

## Test plan
- Reset mid-CALC of MULTU: assert `rst` at cycle 10 -> `hi`=`lo`=0, `busy`=0, no `done`. A fresh MULT 3×4 then gives LO=12, HI=0.
- MULT a=0xFFFFFFFF, b=0x00000002 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with MULTU -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIV by zero with a=0x12345678 -> LO=0xFFFFFFFF, HI=0x12345678, `done` at cycle 33.
- Stall/ordering:
  - `mf_req` held from cycle 1 after a MULT start -> `stall`=1 for cycles 1–32 and 0 at cycle 33.
  - An MTLO at cycle 5 is ignored.
  - `start`+`hi_we` together in IDLE -> op runs and the HI write is dropped.
- With `MULDIV_DIV_EN` undefined: DIVU 100/7 -> `busy` never rises, `done` at cycle 1, HI/LO unchanged.
